// File: rtl/mem_access_ctrl_if.sv
// Request, data-memory and buffer-register signals of the load/store
// sequencer, bundled with a view for each side.
interface mem_access_ctrl_if #(
   parameter int DATA_WIDTH     = 32,
   parameter int MEM_ADDR_WIDTH = 32
);
   logic                      req_valid;
   logic                      req_ready;
   logic                      req_we;
   logic [1:0]                req_size;
   logic                      req_signed;
   logic [MEM_ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0]     req_wdata;
   logic                      mem_cmd_valid;
   logic                      mem_cmd_ready;
   logic                      mem_cmd_we;
   logic [MEM_ADDR_WIDTH-1:0] mem_cmd_addr;
   logic [DATA_WIDTH-1:0]     mem_cmd_wdata;
   logic [DATA_WIDTH/8-1:0]   mem_cmd_be;
   logic                      mem_rsp_valid;
   logic [DATA_WIDTH-1:0]     mem_rsp_rdata;
   logic                      mbr_wr_en;
   logic [DATA_WIDTH-1:0]     mbr_data;
   logic                      done;
   logic                      err;

   modport slave (
      input  req_valid, req_we, req_size,
      input  req_signed, req_addr, req_wdata,
      output req_ready,
      output mem_cmd_valid, mem_cmd_we,
      output mem_cmd_addr, mem_cmd_wdata,
      output mem_cmd_be,
      input  mem_cmd_ready,
      input  mem_rsp_valid, mem_rsp_rdata,
      output mbr_wr_en, mbr_data, done, err
   );

   modport master (
      output req_valid, req_we, req_size,
      output req_signed, req_addr, req_wdata,
      input  req_ready,
      input  mem_cmd_valid, mem_cmd_we,
      input  mem_cmd_addr, mem_cmd_wdata,
      input  mem_cmd_be,
      output mem_cmd_ready,
      output mem_rsp_valid, mem_rsp_rdata,
      input  mbr_wr_en, mbr_data, done, err
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer: one request, one memory command/response,
// lane extraction and extension into the memory buffer register.
module mem_access_ctrl #(
   parameter int DATA_WIDTH     = 32,
   parameter int MEM_ADDR_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic             clk,
   input  logic             async_rst_n,
   input  logic             clk_en,
   mem_access_ctrl_if.slave bus
);
   localparam int BE_W = DATA_WIDTH / 8;
   localparam int CW   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] T_MAX  = CW'(TIMEOUT_CYCLES);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CMD  = 2'd1;
   localparam logic [1:0] RSP  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]                state;
   logic                      rst_s1;
   logic                      rst_n;
   logic                      r_we;
   logic [1:0]                r_size;
   logic                      r_signed;
   logic [MEM_ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0]     r_wdata;
   logic                      fail;
   logic [CW-1:0]             tcnt;
   logic [DATA_WIDTH-1:0]     mbr;
   logic                      misaligned;
   logic [BE_W-1:0]           be;
   logic [DATA_WIDTH-1:0]     wdata;
   logic [DATA_WIDTH-1:0]     lane;
   logic [DATA_WIDTH-1:0]     ext;
   logic                      in_cmd;
   logic                      st_cmd;

   // Release is re-timed to clk; assertion bypasses the flops.
   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         rst_s1 <= 1'b0;
         rst_n  <= 1'b0;
      end else begin
         rst_s1 <= 1'b1;
         rst_n  <= rst_s1;
      end
   end

   always_comb begin
      misaligned = 1'b1;
      case (bus.req_size)
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = bus.req_addr[0];
         2'b10:   misaligned = |bus.req_addr[1:0];
         default: misaligned = 1'b1;
      endcase
   end

   always_comb begin
      be    = '1;
      wdata = r_wdata;
      case (r_size)
         2'b00: begin
            be    = BE_W'(1) << r_addr[1:0];
            wdata = {4{r_wdata[7:0]}};
         end
         2'b01: begin
            be    = r_addr[1] ? 4'b1100 : 4'b0011;
            wdata = {2{r_wdata[15:0]}};
         end
         default: be = '1;
      endcase
   end

   // Aligned halves sit at offset 0 or 2, so one byte shift serves both.
   always_comb begin
      lane = bus.mem_rsp_rdata >> {r_addr[1:0], 3'b000};
      ext  = bus.mem_rsp_rdata;
      case (r_size)
         2'b00: ext = r_signed ? {{24{lane[7]}}, lane[7:0]}
                               : {24'd0, lane[7:0]};
         2'b01: ext = r_signed ? {{16{lane[15]}}, lane[15:0]}
                               : {16'd0, lane[15:0]};
         default: ext = bus.mem_rsp_rdata;
      endcase
   end

   assign in_cmd = (state == CMD);
   assign st_cmd = in_cmd & r_we;

   assign bus.req_ready     = (state == IDLE) & rst_n;
   assign bus.mem_cmd_valid = in_cmd;
   assign bus.mem_cmd_we    = st_cmd;
   assign bus.mem_cmd_addr  = in_cmd ? {r_addr[MEM_ADDR_WIDTH-1:2], 2'b00}
                                     : '0;
   assign bus.mem_cmd_be    = st_cmd ? be : '0;
   assign bus.mem_cmd_wdata = st_cmd ? wdata : '0;
   assign bus.done          = (state == DONE);
   assign bus.err           = (state == DONE) & fail;
   assign bus.mbr_wr_en     = (state == DONE) & ~fail & ~r_we;
   assign bus.mbr_data      = mbr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         r_we     <= 1'b0;
         r_size   <= 2'b00;
         r_signed <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         fail     <= 1'b0;
         tcnt     <= '0;
         mbr      <= '0;
      end else if (clk_en) begin
         unique case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  r_we     <= bus.req_we;
                  r_size   <= bus.req_size;
                  r_signed <= bus.req_signed;
                  r_addr   <= bus.req_addr;
                  r_wdata  <= bus.req_wdata;
                  fail     <= misaligned;
                  tcnt     <= '0;
                  state    <= misaligned ? DONE : CMD;
               end
            end
            CMD, RSP: begin
               if (tcnt != T_MAX) tcnt <= tcnt + 1'b1;
               // A handshake on the limit cycle still completes the access.
               if (in_cmd && bus.mem_cmd_ready) begin
                  state <= r_we ? DONE : RSP;
               end else if (!in_cmd && bus.mem_rsp_valid) begin
                  mbr   <= ext;
                  state <= DONE;
               end else if (tcnt >= T_LAST) begin
                  fail  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: vector table with a
// result scoreboard, plus sequences for stalls, timeout and reset.
module tb_mem_access_ctrl;
   logic clk = 1'b0;
   logic async_rst_n;
   logic clk_en;

   always #5 clk = ~clk;

   mem_access_ctrl_if #(.DATA_WIDTH(32), .MEM_ADDR_WIDTH(32)) bus ();

   mem_access_ctrl #(
      .DATA_WIDTH(32),
      .MEM_ADDR_WIDTH(32),
      .TIMEOUT_CYCLES(4)
   ) dut (
      .clk(clk),
      .async_rst_n(async_rst_n),
      .clk_en(clk_en),
      .bus(bus)
   );

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [31:0] c_addr;
      logic [31:0] c_wdata;
      logic [3:0]  c_be;
      logic        e_err;
      logic [31:0] e_mbr;
      int          lat;
   } vec_t;

   typedef struct {
      logic        err;
      logic        wr;
      logic [31:0] mbr;
   } exp_t;

   vec_t        tbl[13];
   exp_t        sbq[$];
   int          n_vec = 0;
   int          n_bad = 0;
   logic [31:0] last_mbr = 32'h0;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(
      input logic we, input logic [1:0] size, input logic sgn,
      input logic [31:0] addr, input logic [31:0] wdata,
      input logic [31:0] rdata, input logic [31:0] c_addr,
      input logic [31:0] c_wdata, input logic [3:0] c_be,
      input logic e_err, input logic [31:0] e_mbr, input int lat);
      vec_t v;
      v.we = we; v.size = size; v.sgn = sgn;
      v.addr = addr; v.wdata = wdata; v.rdata = rdata;
      v.c_addr = c_addr; v.c_wdata = c_wdata; v.c_be = c_be;
      v.e_err = e_err; v.e_mbr = e_mbr; v.lat = lat;
      return v;
   endfunction

   task automatic drive_req(input logic we, input logic [1:0] size,
                            input logic sgn, input logic [31:0] addr,
                            input logic [31:0] wdata);
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_size   = size;
      bus.req_signed = sgn;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
   endtask

   task automatic run_vec(input int i, input vec_t v);
      exp_t e;
      exp_t g;
      int   cyc;
      bit   got;
      bit   cmd_seen;
      @(negedge clk);
      check($sformatf("v%0d req_ready", i), bus.req_ready, 1);
      drive_req(v.we, v.size, v.sgn, v.addr, v.wdata);
      bus.mem_cmd_ready = 1'b1;
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_rdata = v.rdata;
      e.err = v.e_err;
      e.wr  = !v.we && !v.e_err;
      if (e.wr) last_mbr = v.e_mbr;
      e.mbr = last_mbr;
      sbq.push_back(e);
      got = 1'b0;
      cmd_seen = 1'b0;
      cyc = 99;
      for (int c = 1; c <= 10 && !got; c++) begin
         @(negedge clk);
         bus.req_valid = 1'b0;
         if (bus.mem_cmd_valid) begin
            cmd_seen = 1'b1;
            check($sformatf("v%0d cmd_addr", i), bus.mem_cmd_addr, v.c_addr);
            check($sformatf("v%0d cmd_be", i), 32'(bus.mem_cmd_be),
                  32'(v.c_be));
            check($sformatf("v%0d cmd_wdata", i), bus.mem_cmd_wdata,
                  v.c_wdata);
            check($sformatf("v%0d cmd_we", i), 32'(bus.mem_cmd_we),
                  32'(v.we));
         end
         if (bus.done) begin
            got = 1'b1;
            cyc = c;
            if (sbq.size() == 0) begin
               check($sformatf("v%0d sb_empty", i), 1, 0);
            end else begin
               g = sbq.pop_front();
               check($sformatf("v%0d err", i), 32'(bus.err), 32'(g.err));
               check($sformatf("v%0d mbr_wr_en", i), 32'(bus.mbr_wr_en),
                     32'(g.wr));
               check($sformatf("v%0d mbr_data", i), bus.mbr_data, g.mbr);
            end
         end
      end
      check($sformatf("v%0d latency", i), cyc, v.lat);
      check($sformatf("v%0d cmd_issued", i), 32'(cmd_seen),
            32'(!v.e_err));
      @(negedge clk);
      check($sformatf("v%0d done_pulse", i), 32'(bus.done), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = mk(0, 2'b00, 1, 32'h1003, 0, 32'h80AB_CDEF,
                   32'h1000, 0, 4'b0000, 0, 32'hFFFF_FF80, 3);
      tbl[1]  = mk(0, 2'b01, 0, 32'h2002, 0, 32'hBEEF_1234,
                   32'h2000, 0, 4'b0000, 0, 32'h0000_BEEF, 3);
      tbl[2]  = mk(0, 2'b01, 1, 32'h2002, 0, 32'hBEEF_1234,
                   32'h2000, 0, 4'b0000, 0, 32'hFFFF_BEEF, 3);
      tbl[3]  = mk(0, 2'b00, 0, 32'h1001, 0, 32'h80AB_CDEF,
                   32'h1000, 0, 4'b0000, 0, 32'h0000_00CD, 3);
      tbl[4]  = mk(0, 2'b10, 1, 32'h0040, 0, 32'h1234_5678,
                   32'h0040, 0, 4'b0000, 0, 32'h1234_5678, 3);
      tbl[5]  = mk(0, 2'b01, 1, 32'h0000, 0, 32'hBEEF_7FFF,
                   32'h0000, 0, 4'b0000, 0, 32'h0000_7FFF, 3);
      tbl[6]  = mk(1, 2'b10, 0, 32'h0104, 32'hDEAD_BEEF, 32'h0,
                   32'h0104, 32'hDEAD_BEEF, 4'b1111, 0, 0, 2);
      tbl[7]  = mk(1, 2'b01, 0, 32'h0022, 32'hFFFF_1234, 32'h0,
                   32'h0020, 32'h1234_1234, 4'b1100, 0, 0, 2);
      tbl[8]  = mk(1, 2'b00, 0, 32'h0013, 32'h0000_00A5, 32'h0,
                   32'h0010, 32'hA5A5_A5A5, 4'b1000, 0, 0, 2);
      tbl[9]  = mk(0, 2'b10, 0, 32'h0006, 0, 32'h5555_5555,
                   0, 0, 4'b0000, 1, 0, 1);
      tbl[10] = mk(0, 2'b01, 0, 32'h0003, 0, 32'h5555_5555,
                   0, 0, 4'b0000, 1, 0, 1);
      tbl[11] = mk(0, 2'b11, 0, 32'h0000, 0, 32'h5555_5555,
                   0, 0, 4'b0000, 1, 0, 1);
      tbl[12] = mk(1, 2'b10, 0, 32'h0002, 32'h1111_2222, 32'h0,
                   0, 0, 4'b0000, 1, 0, 1);

      async_rst_n = 1'b0;
      clk_en = 1'b1;
      bus.req_valid = 1'b0;
      drive_req(0, 2'b00, 0, 0, 0);
      bus.req_valid = 1'b0;
      bus.mem_cmd_ready = 1'b0;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_rdata = '0;
      #1;
      check("rst req_ready", 32'(bus.req_ready), 0);
      check("rst cmd_valid", 32'(bus.mem_cmd_valid), 0);
      check("rst done", 32'(bus.done), 0);
      check("rst mbr_data", bus.mbr_data, 0);
      repeat (2) @(negedge clk);
      async_rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst req_ready", 32'(bus.req_ready), 1);

      foreach (tbl[i]) run_vec(i, tbl[i]);
      check("sb drained", sbq.size(), 0);

      // Byte store with the memory stalling three cycles.
      @(negedge clk);
      bus.mem_cmd_ready = 1'b0;
      bus.mem_rsp_valid = 1'b0;
      drive_req(1, 2'b00, 0, 32'h11, 32'h5A);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         bus.req_valid = 1'b0;
         check($sformatf("st%0d valid", k), 32'(bus.mem_cmd_valid), 1);
         check($sformatf("st%0d addr", k), bus.mem_cmd_addr, 32'h10);
         check($sformatf("st%0d be", k), 32'(bus.mem_cmd_be), 32'h2);
         check($sformatf("st%0d wdata", k), bus.mem_cmd_wdata,
               32'h5A5A_5A5A);
         check($sformatf("st%0d wr_en", k), 32'(bus.mbr_wr_en), 0);
         if (k == 4) bus.mem_cmd_ready = 1'b1;
      end
      @(negedge clk);
      bus.mem_cmd_ready = 1'b0;
      check("st done", 32'(bus.done), 1);
      check("st err", 32'(bus.err), 0);
      check("st wr_en", 32'(bus.mbr_wr_en), 0);
      check("st mbr hold", bus.mbr_data, last_mbr);

      // Load with no response: timeout after four enabled cycles.
      @(negedge clk);
      bus.mem_cmd_ready = 1'b1;
      drive_req(0, 2'b10, 0, 32'h200, 0);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         bus.req_valid = 1'b0;
         check($sformatf("to%0d done", k), 32'(bus.done), 0);
      end
      @(negedge clk);
      check("to done", 32'(bus.done), 1);
      check("to err", 32'(bus.err), 1);
      check("to wr_en", 32'(bus.mbr_wr_en), 0);
      @(negedge clk);
      check("to ready", 32'(bus.req_ready), 1);

      // Timeout in CMD with clk_en low every other edge.
      bus.mem_cmd_ready = 1'b0;
      drive_req(0, 2'b10, 0, 32'h300, 0);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         bus.req_valid = 1'b0;
         check($sformatf("ce%0d done", k), 32'(bus.done), 0);
         check($sformatf("ce%0d valid", k), 32'(bus.mem_cmd_valid), 1);
         clk_en = (k % 2 == 0);
      end
      @(negedge clk);
      check("ce done", 32'(bus.done), 1);
      check("ce err", 32'(bus.err), 1);
      check("ce valid drop", 32'(bus.mem_cmd_valid), 0);
      clk_en = 1'b0;
      @(negedge clk);
      check("ce hold done", 32'(bus.done), 1);
      check("ce hold err", 32'(bus.err), 1);
      clk_en = 1'b1;
      @(negedge clk);
      check("ce after done", 32'(bus.done), 0);
      check("ce after ready", 32'(bus.req_ready), 1);

      // Reset while waiting for a response.
      bus.mem_cmd_ready = 1'b1;
      drive_req(0, 2'b00, 1, 32'h1000, 0);
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      check("rr in_rsp valid", 32'(bus.mem_cmd_valid), 0);
      check("rr in_rsp done", 32'(bus.done), 0);
      #2 async_rst_n = 1'b0;
      #1;
      check("rr req_ready", 32'(bus.req_ready), 0);
      check("rr done", 32'(bus.done), 0);
      check("rr err", 32'(bus.err), 0);
      check("rr wr_en", 32'(bus.mbr_wr_en), 0);
      check("rr mbr_data", bus.mbr_data, 0);
      @(negedge clk);
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_rdata = 32'h1122_3344;
      @(negedge clk);
      async_rst_n = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         check($sformatf("rr%0d done", k), 32'(bus.done), 0);
         check($sformatf("rr%0d wr_en", k), 32'(bus.mbr_wr_en), 0);
      end
      check("rr ready back", 32'(bus.req_ready), 1);
      bus.mem_rsp_valid = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Load/store sequencer directly upstream of the memory buffer register.
- Accepts one load/store request from the execute stage and runs one command/response transaction on the data-memory port.
- For loads, extracts the addressed byte/halfword/word and sign- or zero-extends it. It then presents the result with a one-cycle write strobe for the buffer register to capture.
- Flags misaligned accesses and memory timeouts.

Parameters:
- DATA_WIDTH, 32, data bus width. Only 32 is supported; lane logic assumes 4 byte lanes.
- MEM_ADDR_WIDTH, 32, byte address width.
- TIMEOUT_CYCLES, 255, maximum enabled cycles spent waiting in CMD+RSP before the access aborts; must be ≥1.

Ports:
- clk  in  1  clock.
- async_rst_n  in  1  asynchronous active-low reset.
- clk_en  in  1  global clock enable; when low, all state, counters and outputs hold.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE (and not in reset).
- req_we  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal (treated as misaligned).
- req_signed  in  1  sign-extend load result.
- req_addr  in  MEM_ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-justified.
- mem_cmd_valid  out  1  command valid.
- mem_cmd_ready  in  1  memory accepts command.
- mem_cmd_we  out  1  write command.
- mem_cmd_addr  out  MEM_ADDR_WIDTH  word-aligned address ([1:0]=0).
- mem_cmd_wdata  out  DATA_WIDTH  store data replicated to the addressed lanes.
- mem_cmd_be  out  DATA_WIDTH/8  byte enables.
- mem_rsp_valid  in  1  read data valid.
- mem_rsp_rdata  in  DATA_WIDTH  read word.
- mbr_wr_en  out  1  one-cycle write strobe to the buffer register.
- mbr_data  out  DATA_WIDTH  extended load result.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done: misaligned or timeout.

Behaviour:
- Reset:
  - Reset is asynchronous assert, synchronous release.
  - State goes to IDLE; all outputs and the timeout counter go to 0 (req_ready=0 while async_rst_n low).
  - Reset mid-transaction abandons it: no done, no mbr_wr_en.
- Global clock enable: all transitions and samples below occur only on edges with clk_en=1. mem_rsp_valid and mem_cmd_ready are ignored when clk_en=0.
- States: IDLE, CMD, RSP, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid, latch all req_* fields.
  - Misaligned (half with addr[0]=1; word with addr[1:0]≠0; size 11): go to DONE with err=1; no bus command is issued.
  - Otherwise go to CMD.
- CMD:
  - mem_cmd_valid=1; all cmd fields are stable until handshake.
  - On mem_cmd_ready: loads go to RSP; stores go to DONE.
- RSP:
  - Waits for mem_rsp_valid.
  - On mem_rsp_valid, select lane by addr[1:0]: byte lane = addr[1:0]; half lane = addr[1].
  - Extend to 32 bits: sign-extend if req_signed, else zero-extend.
  - Register the result into mbr_data and go to DONE.
- DONE:
  - done=1 for one enabled cycle, then return to IDLE.
  - mbr_wr_en=1 only for a successful load.
  - err held 1 for the DONE cycle if the access failed.
  - mbr_data holds its last value until the next load completes.
- Byte enables:
  - byte: 1<<addr[1:0].
  - half: 0011 or 1100.
  - word: 1111.
- Store data replication:
  - byte: wdata[7:0] ×4.
  - half: wdata[15:0] ×2.
- Timeout:
  - Counter clears on entering CMD and increments each enabled cycle in CMD/RSP.
  - When the count reaches TIMEOUT_CYCLES with no completing handshake, drop mem_cmd_valid and go to DONE with err=1.
  - A handshake in the same cycle as the limit wins: the access completes normally.
- A mem_rsp_valid seen outside RSP is ignored.
- Back-to-back requests: minimum 1 IDLE cycle between transactions.
- Minimum latency, zero-wait memory:
  - Load: accept T0, CMD T1, RSP T2, DONE T3.
  - Store: accept T0, CMD T1, DONE T2.

Test Plan:
1. Signed byte load, addr=0x1003, rsp_rdata=0x80AB_CDEF, zero-wait → cmd_addr=0x1000, be=0000; at T3, mbr_wr_en=1, mbr_data=0xFFFF_FF80, done=1, err=0.
2. Unsigned half load, addr=0x2002, rsp=0xBEEF_1234 → mbr_data=0x0000_BEEF. Repeat signed → 0xFFFF_BEEF.
3. Byte store, addr=0x11, wdata=0x5A, cmd_ready held low 3 cycles → mem_cmd_valid and fields stable for 4 cycles; be=0010, wdata=0x5A5A_5A5A; done 1 cycle after handshake; mbr_wr_en never 1.
4. Word load, addr=0x6 → no mem_cmd_valid; next cycle done=1, err=1, mbr_wr_en=0; req_ready returns 1 the cycle after.
5. TIMEOUT_CYCLES=4, load, no response → done=1, err=1 exactly 4 enabled cycles after entering CMD. Same test with clk_en low every other cycle → timeout stretches to 8 clocks, outputs frozen during low cycles.
6. Assert async_rst_n low mid-edge while in RSP → all outputs 0 immediately without a clock; after release, a late mem_rsp_valid is ignored and no done is produced.
